// File: rtl/mul_radix2_pkg.sv
// mul_pkg: shared constants and state encoding for the radix-2 multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//   MUL_W          operand width
//   MUL_ITER       iterations for a full-width multiplier
//   MUL_ITER_SHORT iterations when the multiplier magnitude fits in 16 bits
//   CNT_W          width of the iteration counter (must hold MUL_ITER)
package mul_pkg;

   localparam int MUL_W          = 32;
   localparam int MUL_ITER       = 32;
   localparam int MUL_ITER_SHORT = 16;
   localparam int CNT_W          = 6;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } mul_state_t;

endpackage

// File: rtl/mul_radix2_twos_neg.sv
// twos_neg: conditional two's-complement negation, out = en ? -in : in.
// Latency: combinational.
// Backpressure: none.
//   in   [W-1:0]  value to (optionally) negate
//   en            1 = negate
//   out  [W-1:0]  result
module twos_neg #(
   parameter int W = 32
) (
   input  logic [W-1:0] in,
   input  logic         en,
   output logic [W-1:0] out
);

   assign out = en ? -in : in;

endmodule

// File: rtl/mul_radix2.sv
// mul_radix2: multi-cycle radix-2 shift-add multiplier for MULT/MULTU.
// Latency: accept on edge T, mul_stall high T+1..T+N (N=32, or 16 with early exit), result from T+N+1.
// Backpressure: none; valid is ignored while mul_stall is high, flush aborts an operation.
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   a, b   [31:0]     multiplicand / multiplier
//   valid             level-sensitive start request, taken only when idle
//   sign              1 = signed (MULT), 0 = unsigned (MULTU)
//   flush             synchronous abort; in idle it also blocks an accept
//   mul_stall         high while an operation is in flight (= |cnt)
//   result [63:0]     {HI, LO}, valid once mul_stall has dropped
// Optional build macro: MUL_EARLY_EXIT_EN -- finish in 16 iterations when the
// multiplier magnitude has no bits above bit 15.
module mul_radix2
   import mul_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [MUL_W-1:0]     a,
   input  logic [MUL_W-1:0]     b,
   input  logic                 valid,
   input  logic                 sign,
   input  logic                 flush,
   output logic                 mul_stall,
   output logic [2*MUL_W-1:0]   result
);

   localparam logic [CNT_W-1:0] N_LONG = CNT_W'(MUL_ITER);

   // state doubles as the busy flag (ST_RUN == busy)
   mul_state_t          state;
   logic [CNT_W-1:0]    cnt;
   // Only the operand sign bits are needed after accept.
   logic                a_save;
   logic                b_save;
   logic                sign_save;
   logic [MUL_W-1:0]    mcand;
   logic [2*MUL_W:0]    p;

   logic [MUL_W-1:0]    a_mag;
   logic [MUL_W-1:0]    b_mag;
   logic [MUL_W:0]      add_term;
   logic [MUL_W:0]      sum;
   logic [2*MUL_W:0]    p_step;
   logic [CNT_W-1:0]    n_last;
   logic [2*MUL_W-1:0]  mag;

   twos_neg #(.W(MUL_W)) u_neg_a (
      .in  (a),
      .en  (sign & a[MUL_W-1]),
      .out (a_mag)
   );

   twos_neg #(.W(MUL_W)) u_neg_b (
      .in  (b),
      .en  (sign & b[MUL_W-1]),
      .out (b_mag)
   );

   // One shift-add step: add the multiplicand into the upper half when the
   // current multiplier bit (P[0]) is set, then shift the whole thing right.
   // The add is 33 bits wide so the carry lands in P[64] before the shift.
   always_comb begin
      add_term = p[0] ? {1'b0, mcand} : '0;
      sum      = p[2*MUL_W:MUL_W] + add_term;
      p_step   = {sum, p[MUL_W-1:0]} >> 1;
   end

`ifdef MUL_EARLY_EXIT_EN
   localparam logic [CNT_W-1:0] N_SHORT = CNT_W'(MUL_ITER_SHORT);

   logic short_q;
   logic short_op;

   assign short_op = (b_mag[MUL_W-1:MUL_W/2] == '0);
   assign n_last   = short_q ? N_SHORT : N_LONG;
   // After 16 steps the product sits 16 bits too high in P; realign it.
   assign mag      = short_q ? (p[2*MUL_W-1:0] >> MUL_ITER_SHORT) : p[2*MUL_W-1:0];
`else
   assign n_last   = N_LONG;
   assign mag      = p[2*MUL_W-1:0];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         a_save    <= 1'b0;
         b_save    <= 1'b0;
         sign_save <= 1'b0;
         mcand     <= '0;
         p         <= '0;
`ifdef MUL_EARLY_EXIT_EN
         short_q   <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (valid & ~flush) begin
                  a_save    <= a[MUL_W-1];
                  b_save    <= b[MUL_W-1];
                  sign_save <= sign;
                  mcand     <= a_mag;
                  p         <= {{(MUL_W+1){1'b0}}, b_mag};
                  cnt       <= CNT_W'(1);
                  state     <= ST_RUN;
`ifdef MUL_EARLY_EXIT_EN
                  short_q   <= short_op;
`endif
               end
            end
            ST_RUN: begin
               if (flush) begin
                  cnt   <= '0;
                  state <= ST_IDLE;
               end else begin
                  p <= p_step;
                  if (cnt == n_last) begin
                     cnt   <= '0;
                     state <= ST_IDLE;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            default: begin
               cnt   <= '0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign mul_stall = |cnt;

   // Product is unsigned magnitude; negate when a signed op had mixed signs.
   twos_neg #(.W(2*MUL_W)) u_neg_res (
      .in  (mag),
      .en  (sign_save & (a_save ^ b_save)),
      .out (result)
   );

endmodule

// File: tb/tb_mul_radix2.sv
// tb_mul_radix2: randomized + directed scoreboard bench for mul_radix2.
// Latency: n/a.
// Backpressure: n/a.
module tb_mul_radix2;

   logic        clk;
   logic        rst;
   logic [31:0] a;
   logic [31:0] b;
   logic        valid;
   logic        sign;
   logic        flush;
   logic        mul_stall;
   logic [63:0] result;

   mul_radix2 dut (
      .clk       (clk),
      .rst       (rst),
      .a         (a),
      .b         (b),
      .valid     (valid),
      .sign      (sign),
      .flush     (flush),
      .mul_stall (mul_stall),
      .result    (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] exp;
      int          lat;
      bit          chk_res;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Reference model: plain arithmetic on the operands.
   function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y, input bit s);
      longint      sx;
      longint      sy;
      logic [63:0] ux;
      logic [63:0] uy;
      if (s) begin
         sx = longint'($signed(x));
         sy = longint'($signed(y));
         return 64'(sx * sy);
      end
      ux = {32'h0, x};
      uy = {32'h0, y};
      return ux * uy;
   endfunction

   function automatic int ref_lat(input logic [31:0] y, input bit s);
`ifdef MUL_EARLY_EXIT_EN
      logic [31:0] ym;
      ym = (s && y[31]) ? (32'h0 - y) : y;
      return (ym < 32'h0001_0000) ? 16 : 32;
`else
      return (s && y[31]) ? 32 : 32;
`endif
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h8000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h0;
         3:       return 32'($urandom_range(0, 65535));
         4:       return 32'h0 - 32'($urandom_range(1, 65535));
         default: return 32'($urandom);
      endcase
   endfunction

   // Monitor: counts stall cycles and checks the result on each stall fall.
   int stall_cyc = 0;
   bit stall_prev = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         stall_cyc  = 0;
         stall_prev = 1'b0;
      end else begin
         if (mul_stall) begin
            stall_cyc++;
         end else if (stall_prev) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_done: stall fell with no operation pending (got %0d stall cycles, required none)", stall_cyc);
            end else begin
               e = exp_q.pop_front();
               check({e.name, "_lat"}, 64'(stall_cyc), 64'(e.lat));
               if (e.chk_res) check({e.name, "_res"}, result, e.exp);
            end
            stall_cyc = 0;
         end
         stall_prev = mul_stall;
      end
   end

   // Caller is at posedge+1 with the multiplier idle.
   task automatic start_op(input logic [31:0] x, input logic [31:0] y, input bit s,
                           input string name, input bit push);
      exp_t e;
      if (push) begin
         e.exp     = ref_prod(x, y, s);
         e.lat     = ref_lat(y, s);
         e.chk_res = 1'b1;
         e.name    = name;
         exp_q.push_back(e);
      end
      a     = x;
      b     = y;
      sign  = s;
      valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (mul_stall && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      n_chk++;
      if (n < 100) n_pass++;
      else $display("FAIL %s_timeout: stall still high after %0d cycles, required drop within 100", name, n);
   endtask

   initial begin
      exp_t e;
      rst   = 1'b1;
      a     = '0;
      b     = '0;
      valid = 1'b0;
      sign  = 1'b0;
      flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_stall", 64'(mul_stall), 64'h0);
      check("reset_result", result, 64'h0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed cases
      start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "umax", 1'b1);      wait_done("umax");
      start_op(32'hFFFF_FFFD, 32'h0000_0007, 1'b1, "s_m3x7", 1'b1);    wait_done("s_m3x7");
      start_op(32'hFFFF_FFFD, 32'h0000_0007, 1'b0, "u_m3x7", 1'b1);    wait_done("u_m3x7");
      start_op(32'h8000_0000, 32'h8000_0000, 1'b1, "s_minsq", 1'b1);   wait_done("s_minsq");
      start_op(32'h8000_0000, 32'h0000_0001, 1'b1, "s_minx1", 1'b1);   wait_done("s_minx1");
      start_op(32'h1234_5678, 32'h0000_0100, 1'b0, "early", 1'b1);     wait_done("early");

      // Busy protection: a new request mid-operation is ignored.
      start_op(32'd5, 32'd6, 1'b0, "busy", 1'b1);
      repeat (7) begin @(posedge clk); #1; end
      a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
      wait_done("busy");
      check("busy_value", result, 64'd30);

      // Flush at cnt=10: stall drops on the next cycle.
      e.exp = '0; e.lat = 10; e.chk_res = 1'b0; e.name = "flush";
      exp_q.push_back(e);
      start_op(32'd7, 32'd9, 1'b0, "flush", 1'b0);
      repeat (9) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_stall", 64'(mul_stall), 64'h0);
      start_op(32'd2, 32'd3, 1'b0, "after_flush", 1'b1);  wait_done("after_flush");

      // Flush beats valid in idle.
      a = 32'd11; b = 32'd13; sign = 1'b0; valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0; flush = 1'b0;
      check("idle_flush_noaccept", 64'(mul_stall), 64'h0);

      // Reset mid-operation at cnt=20.
      start_op(32'd123, 32'd456, 1'b0, "rst_mid", 1'b0);
      repeat (19) begin @(posedge clk); #1; end
      rst = 1'b1;
      #1;
      check("rst_mid_stall", 64'(mul_stall), 64'h0);
      check("rst_mid_result", result, 64'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Randomized, issued back-to-back in the first idle cycle.
      for (int i = 0; i < 40; i++) begin
         start_op(pick(), pick(), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i), 1'b1);
         wait_done($sformatf("rnd%0d", i));
      end

      repeat (3) @(posedge clk);
      check("queue_empty", 64'(exp_q.size()), 64'h0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
      $fatal(1);
   end

endmodule
